uart_rx: RTL
============

# uart_rx

Serial receiver and the counterpart of the existing 9600-baud UART transmitter. It recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous line and presents each byte with a one-cycle valid strobe. It also flags framing errors and ignores start-bit glitches. It sits beside the transmitter under the serial top level, clocked from the same 50 MHz FPGA clock, so the pair forms a loopback-testable link.

## Interface
- CLKS_PER_BIT, 5208, clocks per bit period (50 MHz / 9600 baud); legal range ≥ 4
- i_Clock  in  1  system clock, rising-edge active
- i_Rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_Rx_Serial  in  1  raw serial line, idle high, asynchronous to i_Clock
- o_Rx_DV  out  1  one-cycle strobe: o_Rx_Byte holds a newly received, correctly framed byte
- o_Rx_Byte  out  8  last good byte; holds value until the next good frame
- o_Rx_Busy  out  1  high whenever the receiver is not in IDLE
- o_Rx_Frame_Err  out  1  one-cycle strobe: stop bit sampled low, byte discarded

## Operation
- Input passes through 2-flop synchronizer; all logic below uses synchronized value `rx_s`.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on `rx_s`==0 → START, bit counter cleared.
- START: count to CLKS_PER_BIT/2 (integer division); resample: 0 → DATA (counter cleared, bit index 0); 1 → IDLE (glitch, no strobes).
- DATA: every CLKS_PER_BIT clocks sample `rx_s` into shift register at bit index (LSB first); after index 7 → STOP.
- STOP: after CLKS_PER_BIT clocks sample: 1 → load o_Rx_Byte, pulse o_Rx_DV, → IDLE; 0 → pulse o_Rx_Frame_Err, o_Rx_Byte unchanged, → WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then IDLE (break/stuck-low line never produces repeated errors).
- Counter width $clog2(CLKS_PER_BIT); counters wrap to 0 at terminal count, never overflow.

## Timing
- Reset (async, any state): state IDLE, counters 0, o_Rx_DV 0, o_Rx_Byte 8'h00, o_Rx_Busy 0, o_Rx_Frame_Err 0, synchronizer flops 1. Frame in progress is dropped; no strobe.
- Let cycle 0 = first cycle `rx_s` reads 0 (2 cycles after raw pin edge). Start check at C/2; data bit n sampled at C/2 + (n+1)·C; stop sampled at C/2 + 9·C; o_Rx_DV / o_Rx_Frame_Err high in the following cycle only.
- o_Rx_Busy rises the cycle after cycle 0, falls the same cycle o_Rx_DV rises (or on leaving WAIT_HIGH).
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start edge one half-bit later is accepted with no gap.
- Low pulse shorter than C/2 clocks: no strobe, return to IDLE.
- o_Rx_DV and o_Rx_Frame_Err never high in the same cycle.

## Structure
- Shared package uart_pkg: state encoding enum, default CLKS_PER_BIT (5208), frame constants (DATA_BITS=8); shared with the transmitter.
- One sub-module: sync_2ff (2-flop synchronizer, reset value parameterized, here 1).
- Remainder: single FSM + bit-period counter + 3-bit index + 8-bit shift register in uart_rx.

## Test plan
- CLKS_PER_BIT=16, send 8'h41 (8N1) → o_Rx_DV single pulse 155 clocks after raw start edge, o_Rx_Byte=8'h41, o_Rx_Busy low same cycle.
- Two back-to-back frames 8'h00 then 8'hFF, no idle gap → two DV pulses exactly 160 clocks apart, bytes 8'h00 then 8'hFF.
- 5-clock low glitch on idle line → no DV, no Frame_Err, o_Rx_Busy back low within 10 cycles, o_Rx_Byte unchanged.
- Frame 8'hA5 with stop bit forced low, line held low 3 bit times → one Frame_Err pulse, o_Rx_Byte keeps previous value, o_Rx_Busy high until line returns high, then a following 8'h3C frame is received correctly.
- Assert i_Rst_n low mid-DATA of 8'h55 → all outputs at reset values immediately; no DV after release; next full frame 8'h55 received.
- Loopback with transmitter (CLKS_PER_BIT=5208, byte 8'h41) → o_Rx_Byte=8'h41, one DV per tx done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divisor, frame geometry and FSM state encoding.
// Used by both the receiver and the transmitter so the pair agrees on framing.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } uart_state_e;

    // Plain-vector aliases so legacy logic can hold state in a logic [2:0] register.
    localparam logic [2:0] ST_IDLE      = S_IDLE;
    localparam logic [2:0] ST_START     = S_START;
    localparam logic [2:0] ST_DATA      = S_DATA;
    localparam logic [2:0] ST_STOP      = S_STOP;
    localparam logic [2:0] ST_WAIT_HIGH = S_WAIT_HIGH;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
// Latency 2 clocks; no backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, glitch-rejecting start check, framing-error strobe.
// Byte strobe one clock after the mid-stop sample; no backpressure (strobes are not held).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Busy,
    output logic       o_Rx_Frame_Err
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   BIT_TC   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [7:0]           rx_byte;
    logic [7:0]           rx_byte_nxt;
    logic                 rx_dv_nxt;
    logic                 frame_err_nxt;
    logic                 cnt_tc;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (i_Clock),
        .rst_n (i_Rst_n),
        .d     (i_Rx_Serial),
        .q     (rx_s)
    );

    // Terminal count depends on phase: half a bit to find mid-start, then whole bits.
    always_comb begin
        cnt_tc = 1'b0;
        if (state == ST_START) begin
            cnt_tc = (cnt == HALF_TC);
        end else if (state == ST_DATA || state == ST_STOP) begin
            cnt_tc = (cnt == BIT_TC);
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        rx_byte_nxt   = rx_byte;
        rx_dv_nxt     = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (cnt_tc) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_tc) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt_tc) begin
                    cnt_nxt = '0;
                    // Returning to IDLE at mid-stop lets a back-to-back start edge be seen on time.
                    if (rx_s) begin
                        rx_byte_nxt = shift;
                        rx_dv_nxt   = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            rx_byte        <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bit_idx        <= bit_idx_nxt;
            shift          <= shift_nxt;
            rx_byte        <= rx_byte_nxt;
            o_Rx_DV        <= rx_dv_nxt;
            o_Rx_Frame_Err <= frame_err_nxt;
        end
    end

    assign o_Rx_Byte = rx_byte;
    assign o_Rx_Busy = (state != ST_IDLE);

endmodule
